// File: rtl/gf180mcu_digit_serial_adder.sv
// Digit-serial adder: WIDTH-bit A+B+CI computed DIGIT bits per clock through one shared
// DIGIT-bit slice with a registered carry; valid/ready on both sides, one operation in flight.
module gf180mcu_digit_serial_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CI,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] S,
    output logic             CO,
    output logic             OV
);

    // WIDTH must be a whole number of digits.
    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_s;
    logic             r_co;
    logic             r_ov;
    logic             r_out_valid;

    logic [DIGIT:0]   w_dsum;
    logic [WIDTH-1:0] w_digit_ext;
    logic [WIDTH-1:0] w_res_next;
    logic             w_msb_cin;
    logic             w_last;
    logic             w_accept;
    logic             w_run;

    // Shared adder slice operating on the lowest unprocessed digit.
    assign w_dsum      = {1'b0, r_a_sh[DIGIT-1:0]} + {1'b0, r_b_sh[DIGIT-1:0]}
                       + (DIGIT+1)'(r_carry);
    assign w_digit_ext = WIDTH'(w_dsum[DIGIT-1:0]);
    assign w_res_next  = (r_res >> DIGIT) | (w_digit_ext << (WIDTH - DIGIT));

    // On the last digit, bit DIGIT-1 of the slice is operand bit WIDTH-1.
    assign w_msb_cin   = r_a_sh[DIGIT-1] ^ r_b_sh[DIGIT-1] ^ w_dsum[DIGIT-1];
    assign w_last      = (r_cnt == CW'(NDIG - 1));
    assign w_run       = (r_state == ST_RUN);

    assign IN_READY    = !RST && ((r_state == ST_IDLE) || ((r_state == ST_DONE) && OUT_READY));
    assign w_accept    = IN_VALID && IN_READY;

    assign S           = r_s;
    assign CO          = r_co;
    assign OV          = r_ov;
    assign OUT_VALID   = r_out_valid;

    // Control FSM and result registers; results only move on the edge entering DONE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_s         <= '0;
            r_co        <= 1'b0;
            r_ov        <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_last) begin
                        r_state     <= ST_DONE;
                        r_s         <= w_res_next;
                        r_co        <= w_dsum[DIGIT];
                        r_ov        <= w_msb_cin ^ w_dsum[DIGIT];
                        r_out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (OUT_READY) begin
                        r_out_valid <= 1'b0;
                        r_state     <= w_accept ? ST_RUN : ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Operand shift registers, partial result, digit carry and digit counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_a_sh  <= A;
            r_b_sh  <= B;
            r_carry <= CI;
            r_cnt   <= '0;
        end else if (w_run) begin
            r_a_sh  <= r_a_sh >> DIGIT;
            r_b_sh  <= r_b_sh >> DIGIT;
            r_res   <= w_res_next;
            r_carry <= w_dsum[DIGIT];
            r_cnt   <= r_cnt + CW'(1);
        end
    end

endmodule
